// File: rtl/dec_ex_pipeline_reg.sv
// dec_ex_pipeline_reg
// Decode-to-execute pipeline register of the 5-stage RISC-V core.
// Registers decoded operands and control for the execute stage.
// Each edge applies exactly one action, in this priority order:
//   1. flush: load a bubble.
//   2. stall: hold the contents.
//   3. otherwise: load the decode outputs.
// Captured and held register data is bypassed from the write-back stage.
// Optional build macro: DEC_EX_PERF_CNT_EN adds flush_count/stall_count.
module dec_ex_pipeline_reg #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  dec_valid,
  input  logic [XLEN-1:0]       dec_pc,
  input  logic [XLEN-1:0]       dec_pc_plus4,
  input  logic [XLEN-1:0]       dec_rs1_data,
  input  logic [XLEN-1:0]       dec_rs2_data,
  input  logic [XLEN-1:0]       dec_imm,
  input  logic [4:0]            dec_rs1_addr,
  input  logic [4:0]            dec_rs2_addr,
  input  logic [4:0]            dec_rd_addr,
  input  logic [ALU_CTRL_W-1:0] dec_alu_ctrl,
  input  logic                  dec_alu_src_b,
  input  logic [1:0]            dec_result_src,
  input  logic                  dec_reg_write,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_branch,
  input  logic                  dec_jump,
  input  logic                  wb_reg_write_signal,
  input  logic [4:0]            wb_reg_write_addr,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_pc_plus4,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [4:0]            ex_rs1_addr,
  output logic [4:0]            ex_rs2_addr,
  output logic [4:0]            ex_rd_addr,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic                  ex_alu_src_b,
  output logic [1:0]            ex_result_src,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_jump
`ifdef DEC_EX_PERF_CNT_EN
  ,
  output logic [31:0]           flush_count,
  output logic [31:0]           stall_count
`endif
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [4:0]            r_rs1_addr;
  logic [4:0]            r_rs2_addr;
  logic [4:0]            r_rd_addr;
  logic [ALU_CTRL_W-1:0] r_alu_ctrl;
  logic                  r_alu_src_b;
  logic [1:0]            r_result_src;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_branch;
  logic                  r_jump;

  // Bypass on load.
  // The register file cannot return a value written in this same cycle.
  // x0 is hard-wired, so it is never bypassed.
  logic w_byp_ld_rs1;
  logic w_byp_ld_rs2;
  // Bypass while held.
  // This keeps stalled operands in step with write-back.
  logic w_byp_hold_rs1;
  logic w_byp_hold_rs2;

  assign w_byp_ld_rs1   = wb_reg_write_signal && (wb_reg_write_addr == dec_rs1_addr)
                          && (dec_rs1_addr != 5'd0);
  assign w_byp_ld_rs2   = wb_reg_write_signal && (wb_reg_write_addr == dec_rs2_addr)
                          && (dec_rs2_addr != 5'd0);
  assign w_byp_hold_rs1 = wb_reg_write_signal && (wb_reg_write_addr == r_rs1_addr)
                          && (r_rs1_addr != 5'd0);
  assign w_byp_hold_rs2 = wb_reg_write_signal && (wb_reg_write_addr == r_rs2_addr)
                          && (r_rs2_addr != 5'd0);

  // Control fields, addresses and PC fields.
  // Action order: flush loads a bubble, stall holds, otherwise load.
  // NOTE: every bit is reset, so reset is a true bubble (the hazard unit sees only x0 addresses).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses <= so all flops sample pre-edge values together.
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_pc_plus4   <= '0;
      r_imm        <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd_addr    <= '0;
      r_alu_ctrl   <= '0;
      r_alu_src_b  <= 1'b0;
      r_result_src <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_pc_plus4   <= '0;
      r_imm        <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd_addr    <= '0;
      r_alu_ctrl   <= '0;
      r_alu_src_b  <= 1'b0;
      r_result_src <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
    end else if (!stall) begin
      r_valid      <= dec_valid;
      r_pc         <= dec_pc;
      r_pc_plus4   <= dec_pc_plus4;
      r_imm        <= dec_imm;
      r_rs1_addr   <= dec_rs1_addr;
      r_rs2_addr   <= dec_rs2_addr;
      r_rd_addr    <= dec_rd_addr;
      r_alu_ctrl   <= dec_alu_ctrl;
      r_alu_src_b  <= dec_alu_src_b;
      r_result_src <= dec_result_src;
      r_reg_write  <= dec_reg_write;
      r_mem_read   <= dec_mem_read;
      r_mem_write  <= dec_mem_write;
      r_branch     <= dec_branch;
      r_jump       <= dec_jump;
    end
  end

  // Operand data: the register-file value or the bypassed write-back result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (flush) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (stall) begin
      if (w_byp_hold_rs1) r_rs1_data <= wb_result;
      if (w_byp_hold_rs2) r_rs2_data <= wb_result;
    end else begin
      r_rs1_data <= w_byp_ld_rs1 ? wb_result : dec_rs1_data;
      r_rs2_data <= w_byp_ld_rs2 ? wb_result : dec_rs2_data;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1_addr   = r_rs1_addr;
  assign ex_rs2_addr   = r_rs2_addr;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_alu_ctrl   = r_alu_ctrl;
  assign ex_alu_src_b  = r_alu_src_b;
  assign ex_result_src = r_result_src;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_branch     = r_branch;
  assign ex_jump       = r_jump;

`ifdef DEC_EX_PERF_CNT_EN
  logic [31:0] r_flush_count;
  logic [31:0] r_stall_count;

  // Performance counters.
  // A stall is counted only when it is not masked by a flush.
  // Both counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_count <= '0;
      r_stall_count <= '0;
    end else if (flush) begin
      r_flush_count <= r_flush_count + 32'd1;
    end else if (stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign flush_count = r_flush_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_dec_ex_pipeline_reg.sv
// tb_dec_ex_pipeline_reg
// Self-checking bench for dec_ex_pipeline_reg.
// Each step pushes an expected output onto a queue, from a behavioural model.
// After the edge, the bench pops that entry and compares it with the DUT.
// Define DEC_EX_PERF_CNT_EN to also check the performance counters.
module tb_dec_ex_pipeline_reg;

  localparam int XLEN = 32;
  localparam int ACW  = 4;

  typedef struct packed {
    logic            flush;
    logic            stall;
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [ACW-1:0]  alu_ctrl;
    logic            alu_src_b;
    logic [1:0]      result_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
  } stim_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [ACW-1:0]  alu_ctrl;
    logic            alu_src_b;
    logic [1:0]      result_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
  } out_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, stall, dec_valid;
  logic [XLEN-1:0] dec_pc, dec_pc_plus4, dec_rs1_data, dec_rs2_data, dec_imm;
  logic [4:0]      dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [ACW-1:0]  dec_alu_ctrl;
  logic            dec_alu_src_b;
  logic [1:0]      dec_result_src;
  logic            dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
  logic            wb_reg_write_signal;
  logic [4:0]      wb_reg_write_addr;
  logic [XLEN-1:0] wb_result;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_pc_plus4, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [ACW-1:0]  ex_alu_ctrl;
  logic            ex_alu_src_b;
  logic [1:0]      ex_result_src;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
`ifdef DEC_EX_PERF_CNT_EN
  logic [31:0]     flush_count, stall_count;
`endif

  dec_ex_pipeline_reg #(.XLEN(XLEN), .ALU_CTRL_W(ACW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_alu_ctrl(dec_alu_ctrl), .dec_alu_src_b(dec_alu_src_b),
    .dec_result_src(dec_result_src), .dec_reg_write(dec_reg_write),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_branch(dec_branch), .dec_jump(dec_jump),
    .wb_reg_write_signal(wb_reg_write_signal), .wb_reg_write_addr(wb_reg_write_addr),
    .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src_b(ex_alu_src_b),
    .ex_result_src(ex_result_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump)
`ifdef DEC_EX_PERF_CNT_EN
    , .flush_count(flush_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  out_t  model;
  out_t  sb[$];
  int    exp_flush = 0;
  int    exp_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input out_t e);
    check({tag, ".valid"},      32'(ex_valid),      32'(e.valid));
    check({tag, ".pc"},         ex_pc,              e.pc);
    check({tag, ".pc4"},        ex_pc_plus4,        e.pc4);
    check({tag, ".rs1_data"},   ex_rs1_data,        e.rs1_data);
    check({tag, ".rs2_data"},   ex_rs2_data,        e.rs2_data);
    check({tag, ".imm"},        ex_imm,             e.imm);
    check({tag, ".rs1_addr"},   32'(ex_rs1_addr),   32'(e.rs1_addr));
    check({tag, ".rs2_addr"},   32'(ex_rs2_addr),   32'(e.rs2_addr));
    check({tag, ".rd_addr"},    32'(ex_rd_addr),    32'(e.rd_addr));
    check({tag, ".alu_ctrl"},   32'(ex_alu_ctrl),   32'(e.alu_ctrl));
    check({tag, ".alu_src_b"},  32'(ex_alu_src_b),  32'(e.alu_src_b));
    check({tag, ".result_src"}, 32'(ex_result_src), 32'(e.result_src));
    check({tag, ".ctrl"},
          32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump}),
          32'({e.reg_write, e.mem_read, e.mem_write, e.branch, e.jump}));
  endtask

  // Behavioural model of one clock edge.
  function automatic out_t model_next(input out_t cur, input stim_t s);
    out_t n;
    n = cur;
    if (s.flush) begin
      n = '0;
    end else if (s.stall) begin
      if (s.wb_we && s.wb_addr == cur.rs1_addr && cur.rs1_addr != 5'd0) n.rs1_data = s.wb_data;
      if (s.wb_we && s.wb_addr == cur.rs2_addr && cur.rs2_addr != 5'd0) n.rs2_data = s.wb_data;
    end else begin
      n.valid      = s.valid;
      n.pc         = s.pc;
      n.pc4        = s.pc4;
      n.imm        = s.imm;
      n.rs1_addr   = s.rs1_addr;
      n.rs2_addr   = s.rs2_addr;
      n.rd_addr    = s.rd_addr;
      n.alu_ctrl   = s.alu_ctrl;
      n.alu_src_b  = s.alu_src_b;
      n.result_src = s.result_src;
      n.reg_write  = s.reg_write;
      n.mem_read   = s.mem_read;
      n.mem_write  = s.mem_write;
      n.branch     = s.branch;
      n.jump       = s.jump;
      n.rs1_data   = (s.wb_we && s.wb_addr == s.rs1_addr && s.rs1_addr != 5'd0) ? s.wb_data : s.rs1_data;
      n.rs2_data   = (s.wb_we && s.wb_addr == s.rs2_addr && s.rs2_addr != 5'd0) ? s.wb_data : s.rs2_data;
    end
    return n;
  endfunction

  // NOTE: inputs are driven with blocking assignments on the falling edge, away from the sampling edge.
  task automatic drive(input stim_t s);
    flush = s.flush;             stall = s.stall;
    dec_valid = s.valid;         dec_pc = s.pc;
    dec_pc_plus4 = s.pc4;        dec_rs1_data = s.rs1_data;
    dec_rs2_data = s.rs2_data;   dec_imm = s.imm;
    dec_rs1_addr = s.rs1_addr;   dec_rs2_addr = s.rs2_addr;
    dec_rd_addr = s.rd_addr;     dec_alu_ctrl = s.alu_ctrl;
    dec_alu_src_b = s.alu_src_b; dec_result_src = s.result_src;
    dec_reg_write = s.reg_write; dec_mem_read = s.mem_read;
    dec_mem_write = s.mem_write; dec_branch = s.branch;
    dec_jump = s.jump;           wb_reg_write_signal = s.wb_we;
    wb_reg_write_addr = s.wb_addr;
    wb_result = s.wb_data;
  endtask

  task automatic step(input stim_t s, input string tag);
    out_t e;
    @(negedge clk);
    drive(s);
    model = model_next(model, s);
    sb.push_back(model);
    if (s.flush) exp_flush++;
    else if (s.stall) exp_stall++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  function automatic stim_t base(input logic [31:0] pc, input logic [4:0] rs1,
                                 input logic [31:0] d1, input logic [4:0] rs2,
                                 input logic [31:0] d2);
    stim_t s;
    s = '0;
    s.valid    = 1'b1;
    s.pc       = pc;
    s.pc4      = pc + 32'd4;
    s.imm      = pc ^ 32'h0F0F_0000;
    s.rs1_addr = rs1;
    s.rs1_data = d1;
    s.rs2_addr = rs2;
    s.rs2_data = d2;
    s.rd_addr  = 5'd1;
    return s;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0;
    drive('0);
    model = '0;
    #12;
    check_all("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain load.
    s = base(32'h100, 5'd2, 32'h22, 5'd4, 32'h44);
    s.rd_addr = 5'd5; s.reg_write = 1'b1; s.alu_ctrl = 4'd2;
    s.alu_src_b = 1'b1; s.result_src = 2'd1; s.branch = 1'b1;
    step(s, "load");

    // Asynchronous reset mid-cycle, while ex_reg_write is 1.
    #2;
    rst_n = 1'b0;
    #1;
    model = '0;
    exp_flush = 0;
    exp_stall = 0;
    check_all("async_rst", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // The first edge after reset is a normal load.
    s = base(32'h200, 5'd6, 32'h66, 5'd8, 32'h88);
    s.reg_write = 1'b1; s.mem_read = 1'b1; s.jump = 1'b1; s.result_src = 2'd2;
    step(s, "post_rst_load");

    // Flush has priority over stall; the bubble also clears the addresses.
    s = base(32'h300, 5'd4, 32'h1, 5'd5, 32'h2);
    s.flush = 1'b1; s.stall = 1'b1; s.reg_write = 1'b1;
    step(s, "flush_prio");

    // Stall hold: new decode inputs and an unrelated wb write are ignored.
    s = base(32'h400, 5'd3, 32'h11, 5'd12, 32'h12);
    s.mem_write = 1'b1; s.alu_ctrl = 4'd9;
    step(s, "hold_load");
    for (int i = 0; i < 3; i++) begin
      s = base(32'h500 + 32'(i), 5'd20, 32'hDEAD, 5'd21, 32'hCAFE);
      s.stall = 1'b1; s.reg_write = 1'b1;
      s.wb_we = 1'b1; s.wb_addr = 5'd4; s.wb_data = 32'h9999;
      step(s, $sformatf("hold_%0d", i));
    end

    // Load bypass on rs2, and x0 is never bypassed.
    s = base(32'h600, 5'd1, 32'h10, 5'd7, 32'hAAAA);
    s.wb_we = 1'b1; s.wb_addr = 5'd7; s.wb_data = 32'h1234;
    step(s, "ld_byp_rs2");
    s = base(32'h604, 5'd1, 32'h10, 5'd0, 32'hAAAA);
    s.wb_we = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'h1234;
    step(s, "ld_byp_x0");
    s = base(32'h608, 5'd7, 32'h55, 5'd3, 32'h33);
    s.wb_we = 1'b0; s.wb_addr = 5'd7; s.wb_data = 32'h1234;
    step(s, "ld_no_we");

    // Held bypass: rs1 tracks wb, rs2 (different register) holds.
    s = base(32'h700, 5'd9, 32'h5, 5'd10, 32'h6);
    step(s, "hb_load");
    s = base(32'h704, 5'd1, 32'h0, 5'd2, 32'h0);
    s.stall = 1'b1; s.wb_we = 1'b1; s.wb_addr = 5'd9; s.wb_data = 32'hBEEF;
    step(s, "held_byp");

    // Held bypass on x0 must not happen.
    s = base(32'h710, 5'd0, 32'h77, 5'd11, 32'h7);
    step(s, "hb0_load");
    s = base(32'h714, 5'd1, 32'h0, 5'd2, 32'h0);
    s.stall = 1'b1; s.wb_we = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'hF00D;
    step(s, "held_x0");

    // A flush without a stall.
    s = base(32'h800, 5'd1, 32'h1, 5'd2, 32'h2);
    s.flush = 1'b1;
    step(s, "flush2");

    // Random mix: few register indices, so bypass collisions are frequent.
    for (int i = 0; i < 40; i++) begin
      s            = '0;
      s.flush      = ($urandom_range(0, 7) == 0);
      s.stall      = ($urandom_range(0, 3) == 0);
      s.valid      = 1'($urandom_range(0, 1));
      s.pc         = $urandom;
      s.pc4        = s.pc + 32'd4;
      s.imm        = $urandom;
      s.rs1_addr   = 5'($urandom_range(0, 3));
      s.rs2_addr   = 5'($urandom_range(0, 3));
      s.rd_addr    = 5'($urandom_range(0, 31));
      s.rs1_data   = $urandom;
      s.rs2_data   = $urandom;
      s.alu_ctrl   = 4'($urandom_range(0, 15));
      s.alu_src_b  = 1'($urandom_range(0, 1));
      s.result_src = 2'($urandom_range(0, 3));
      s.reg_write  = 1'($urandom_range(0, 1));
      s.mem_read   = 1'($urandom_range(0, 1));
      s.mem_write  = 1'($urandom_range(0, 1));
      s.branch     = 1'($urandom_range(0, 1));
      s.jump       = 1'($urandom_range(0, 1));
      s.wb_we      = 1'($urandom_range(0, 1));
      s.wb_addr    = 5'($urandom_range(0, 3));
      s.wb_data    = $urandom;
      step(s, $sformatf("rand_%0d", i));
    end

`ifdef DEC_EX_PERF_CNT_EN
    check("flush_count", flush_count, 32'(exp_flush));
    check("stall_count", stall_count, 32'(exp_stall));
`endif

    if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
